// File: rtl/cnt4_sld.sv
// cnt4_sld: synchronous loadable up/down counter, 74163-style, cascadable via ET/TC.
// Optional timing model (specify paths and setup/hold checks) enabled by defining LSI_SPECIFY_EN.
`timescale 1ns/1ps

module cnt4_sld #(
    parameter int  WIDTH   = 4,
    parameter real TP_RISE = 1.10,
    parameter real TP_FALL = 0.40
) (
    input  logic             CP,
    input  logic             RS,
    input  logic             LD,
    input  logic             EP,
    input  logic             ET,
    input  logic             UD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;

    generate
        if (WIDTH < 2 || WIDTH > 16 || TP_RISE < 0.0 || TP_FALL < 0.0) begin : g_bad_param
            $error("cnt4_sld: WIDTH must be 2..16 and delays non-negative");
        end
    endgenerate

    // Every legal control combination is listed; anything unknown falls to default and poisons Q.
    always_ff @(posedge CP) begin
        casez ({RS, LD, EP, ET})
            4'b1???: Q <= ZERO;
            4'b01??: Q <= D;
            4'b0011: begin
                case (UD)
                    1'b1:    Q <= Q + WIDTH'(1);
                    1'b0:    Q <= Q - WIDTH'(1);
                    default: Q <= 'x;
                endcase
            end
            4'b0000,
            4'b0001,
            4'b0010: Q <= Q;
            default: Q <= 'x;
        endcase
    end

    assign TC = ET & ((UD & (Q == ALL_ONES)) | (~UD & (Q == ZERO)));

`ifdef LSI_SPECIFY_EN
    specify
        specparam t_rise  = TP_RISE;
        specparam t_fall  = TP_FALL;
        specparam t_setup = 0.50;
        specparam t_hold  = 0.10;

        (posedge CP *> (Q +: D))  = (t_rise, t_fall);
        (posedge CP => (TC +: ET)) = (t_rise, t_fall);
        (ET, UD *> TC) = (0.30, 0.15);

        $setup(D,  posedge CP, t_setup);
        $setup(LD, posedge CP, t_setup);
        $setup(EP, posedge CP, t_setup);
        $setup(ET, posedge CP, t_setup);
        $setup(UD, posedge CP, t_setup);
        $setup(RS, posedge CP, t_setup);
        $hold(posedge CP, D,  t_hold);
        $hold(posedge CP, LD, t_hold);
        $hold(posedge CP, EP, t_hold);
        $hold(posedge CP, ET, t_hold);
        $hold(posedge CP, UD, t_hold);
        $hold(posedge CP, RS, t_hold);
    endspecify
`endif

endmodule

// File: tb/tb_cnt4_sld.sv
// Directed bench for cnt4_sld: single 4-bit stage plus an 8-bit two-stage cascade, scoreboard-checked.
`timescale 1ns/1ps

module tb_cnt4_sld;

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic       tc;
    } exp_t;

    logic       CP = 1'b0;
    logic       RS, LD, EP, ET, UD;
    logic [3:0] D;
    logic [3:0] Q;
    logic       TC;

    logic       c_rs, c_ld, c_ep, c_ud;
    logic [7:0] c_d;
    logic [3:0] q_lo, q_hi;
    logic       tc_lo, tc_hi;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] model;

    always #5 CP = ~CP;

    cnt4_sld #(.WIDTH(4)) u_dut (
        .CP(CP), .RS(RS), .LD(LD), .EP(EP), .ET(ET), .UD(UD), .D(D), .Q(Q), .TC(TC)
    );

    cnt4_sld #(.WIDTH(4)) u_lo (
        .CP(CP), .RS(c_rs), .LD(c_ld), .EP(c_ep), .ET(1'b1), .UD(c_ud),
        .D(c_d[3:0]), .Q(q_lo), .TC(tc_lo)
    );

    cnt4_sld #(.WIDTH(4)) u_hi (
        .CP(CP), .RS(c_rs), .LD(c_ld), .EP(c_ep), .ET(tc_lo), .UD(c_ud),
        .D(c_d[7:4]), .Q(q_hi), .TC(tc_hi)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic set_in(input logic rs, input logic ld, input logic ep, input logic et,
                          input logic ud, input logic [3:0] d);
        @(negedge CP);
        RS = rs; LD = ld; EP = ep; ET = et; UD = ud; D = d;
    endtask

    task automatic expect_res(input string tag, input logic [7:0] q, input logic tc);
        sb.push_back('{tag: tag, q: q, tc: tc});
    endtask

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic pop_check(input logic [7:0] obs_q, input logic obs_tc);
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        n_tests++;
        assert (obs_q === e.q) else begin
            n_fail++;
            $error("FAIL %s.Q: observed %h expected %h", e.tag, obs_q, e.q);
        end
        n_tests++;
        assert (obs_tc === e.tc) else begin
            n_fail++;
            $error("FAIL %s.TC: observed %b expected %b", e.tag, obs_tc, e.tc);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] q, input logic tc);
        expect_res(tag, {4'h0, q}, tc);
        tick();
        pop_check({4'h0, Q}, TC);
    endtask

    initial begin
        c_rs = 1'b1; c_ld = 1'b0; c_ep = 1'b0; c_ud = 1'b1; c_d = 8'h00;
        RS = 1'b1; LD = 1'b1; EP = 1'b1; ET = 1'b1; UD = 1'b1; D = 4'hA;

        // Reset beats load and count; TC follows UD with no clock.
        step("rst1", 4'h0, 1'b0);
        step("rst2", 4'h0, 1'b0);
        @(negedge CP); UD = 1'b0;
        expect_res("rst_ud0", 8'h00, 1'b1);
        #1; pop_check({4'h0, Q}, TC);

        set_in(0, 1, 1, 1, 1, 4'hD);  step("ld_d", 4'hD, 1'b0);
        set_in(0, 0, 1, 1, 1, 4'h0);
        step("up_e", 4'hE, 1'b0);
        step("up_f", 4'hF, 1'b1);
        step("up_wrap", 4'h0, 1'b0);

        set_in(0, 1, 1, 1, 0, 4'h1);  step("ld_1", 4'h1, 1'b0);
        set_in(0, 0, 1, 1, 0, 4'h0);
        step("dn_0", 4'h0, 1'b1);
        step("dn_wrap", 4'hF, 1'b0);
        step("dn_e", 4'hE, 1'b0);

        set_in(0, 1, 0, 0, 0, 4'h7);  step("ld_7", 4'h7, 1'b0);
        set_in(0, 0, 1, 0, 1, 4'h0);
        for (int i = 0; i < 4; i++) step("et0_hold", 4'h7, 1'b0);
        set_in(0, 0, 0, 1, 1, 4'h0);
        step("ep0_hold1", 4'h7, 1'b0);
        step("ep0_hold2", 4'h7, 1'b0);

        set_in(0, 1, 1, 1, 1, 4'h5);  step("ld_over_cnt", 4'h5, 1'b0);
        set_in(0, 0, 1, 1, 1, 4'h0);  step("dir_up", 4'h6, 1'b0);
        set_in(0, 0, 1, 1, 0, 4'h0);  step("dir_dn", 4'h5, 1'b0);
        set_in(1, 1, 1, 1, 1, 4'h9);  step("rst_mid", 4'h0, 1'b0);
        set_in(0, 1, 0, 0, 1, 4'hF);  step("ld_f_et0", 4'hF, 1'b0);
        @(negedge CP); ET = 1'b1;
        expect_res("tc_et_rise", 8'h0F, 1'b1);
        #1; pop_check({4'h0, Q}, TC);

        // Two-stage cascade: upper stage advances only when the lower one is at terminal count.
        @(negedge CP); c_rs = 1'b0; c_ld = 1'b1; c_d = 8'hFE; c_ep = 1'b1;
        model = 8'hFE;
        expect_res("cas_ld", model, 1'b0);
        tick(); pop_check({q_hi, q_lo}, tc_hi);
        @(negedge CP); c_ld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            model = model + 8'h01;
            expect_res("cas_up", model, model == 8'hFF);
            tick(); pop_check({q_hi, q_lo}, tc_hi);
        end

        n_tests++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain: observed %0d expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cnt4_sld.md
Name: cnt4_sld

Overview:
- Synchronous loadable up/down counter macro for the lsi_10k cell set; 74163-style MSI function.
- Its parallel-load data and enables are driven from AND-NOR/AO gate stages such as the 3-input AND-NOR cell; it is the registered stage directly downstream of them.
- Cascadable through a count-enable-trickle input (ET) and a terminal-count output (TC) for multi-stage counters.
- Timescale 1ns/1ps, consistent with the rest of the library.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..16.
- TP_RISE, 1.10, typical CP->Q/TC rise delay (ns); used only under the optional feature.
- TP_FALL, 0.40, typical CP->Q/TC fall delay (ns); used only under the optional feature.

Ports:
- CP  input  1  clock; all state changes on rising edge.
- RS  input  1  synchronous reset, active-high.
- LD  input  1  synchronous parallel load, active-high.
- EP  input  1  count enable (parallel); does not affect TC.
- ET  input  1  count enable (trickle); gates TC, cascade input.
- UD  input  1  direction: 1 = up, 0 = down.
- D   input  WIDTH  parallel load data.
- Q   output WIDTH  counter state.
- TC  output 1  terminal count, combinational from Q, ET, UD.

Behaviour:
- Rising-edge priority, highest first:
  - RS=1: Q <= 0.
  - Else LD=1: Q <= D. EP, ET and UD are ignored.
  - Else EP=1 and ET=1, UD=1: Q <= Q+1 mod 2^WIDTH.
  - Else EP=1 and ET=1, UD=0: Q <= Q-1 mod 2^WIDTH.
  - Otherwise: hold.
- Wrap-around:
  - Up from all-ones gives 0.
  - Down from 0 gives all-ones.
  - No sticky overflow flag.
- TC = ET & ((UD & Q==all-ones) | (~UD & Q==0)).
  - Purely combinational; no clock latency.
  - Changes as soon as UD or ET changes.
- Reset values:
  - Q = 0.
  - TC = ET & ~UD, because Q=0 is terminal for down-count.
  - No other output state exists.
- Latency:
  - Q updates one CP edge after the qualifying inputs.
  - TC reflects the new Q in the same cycle.
- Simultaneous events:
  - RS wins over LD and count.
  - LD wins over count.
  - Direction change with the enables active takes effect on that same edge.
- Reset mid-count: Q returns to 0 on the edge where RS=1, regardless of the other inputs.
- Cascading:
  - Stage n ET is driven from stage n-1 TC; all stages share CP, RS and EP.
  - The cascade must count correctly with WIDTH=4 stages chained to 8 or 12 bits.
- X handling: an unknown on RS, LD or the enables at an edge drives Q to X. No silent hold.
- Internal structure:
  - Next-state logic may be written behaviourally; a gate-primitive netlist is not required.
  - The single always block is sensitive only to posedge CP.

Optional Feature:
- Macro: LSI_SPECIFY_EN.
- Defined: the module includes a specify block with:
  - (CP => Q) and (CP => TC) edge-sensitive paths using (TP_RISE, TP_FALL).
  - A level path (ET, UD *> TC) = (0.30, 0.15).
  - $setup/$hold checks of D, LD, EP, ET, UD and RS against posedge CP: setup 0.50 ns, hold 0.10 ns.
- Not defined: no specify block, zero-delay functional model; results must be cycle-identical to the timed model at sample points.

Test Plan:
- RS=1 for 2 edges with D=4'hA, LD=1, EP=ET=1 -> Q=0; with UD=1, TC=0; set UD=0 -> TC=1 immediately.
- RS=0, LD=1, D=4'hD, then LD=0, EP=ET=1, UD=1 for 3 edges -> Q=D, E, F, then 0; TC=1 only while Q=F.
- Load 4'h1, UD=0, enables on for 3 edges -> Q=0 (TC=1), then F, then E (TC=0).
- Q=7, EP=1, ET=0 for 4 edges -> Q stays 7 and TC=0; then EP=0, ET=1 -> Q stays 7.
- Two stages cascaded (8-bit), load 8'hFE, count up 3 edges -> FF, 00, 01; upper TC rises only at FF.
- With LSI_SPECIFY_EN: D changing 0.2 ns before a CP edge -> setup violation reported; CP->Q observed at 1.10 ns rise and 0.40 ns fall.
